// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU result-stage types, widths and NZCV bit positions.
package alu_pkg;
  localparam int WIDTH = 32;
  localparam int TAG_W = 5;
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;
  typedef struct packed {
    logic [WIDTH-1:0] sum;
    logic [TAG_W-1:0] dest;
    nzcv_t nzcv;
    logic set_flags;
  } alu_entry_t;
endpackage

// File: rtl/alu_result_stage_if.sv
// alu_result_stage_if: adder-side capture and downstream commit handshakes plus flush/flags.
interface alu_result_stage_if;
  import alu_pkg::*;
  logic in_valid, in_ready, in_cout, in_ovf, in_set_flags, flush, out_valid, out_ready;
  logic [WIDTH-1:0] in_sum, out_result;
  logic [TAG_W-1:0] in_dest, out_dest;
  logic [3:0] out_flags, flags;
  modport master (
    output in_valid, in_sum, in_cout, in_ovf, in_set_flags, in_dest, flush, out_ready,
    input in_ready, out_valid, out_result, out_dest, out_flags, flags
  );
  modport slave (
    input in_valid, in_sum, in_cout, in_ovf, in_set_flags, in_dest, flush, out_ready,
    output in_ready, out_valid, out_result, out_dest, out_flags, flags
  );
endinterface

// File: rtl/alu_flag_gen.sv
// alu_flag_gen: combinational NZCV derivation from adder sum, carry-out and overflow.
module alu_flag_gen
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  input  logic             ovf,
  output nzcv_t            nzcv
);
  logic [3:0] f;
  always_comb begin
    f = '0;
    f[FLAG_N] = sum[WIDTH-1];
    f[FLAG_Z] = sum == '0;
    f[FLAG_C] = cout;
    f[FLAG_V] = ovf;
  end
  assign nzcv = f;
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: registered adder result stage with NZCV capture and architectural flags.
// ALU_RESULT_SKID_EN selects a 2-entry skid buffer with registered in_ready.
module alu_result_stage
  import alu_pkg::*;
(
  input logic clk,
  input logic reset_n,
  alu_result_stage_if.slave io
);
  alu_entry_t h, ent;
  nzcv_t nz, flags_q;
  logic hv, acc, commit;
  alu_flag_gen u_flag_gen (.sum(io.in_sum), .cout(io.in_cout), .ovf(io.in_ovf), .nzcv(nz));
  assign ent = '{sum: io.in_sum, dest: io.in_dest, nzcv: nz, set_flags: io.in_set_flags};
  assign acc = io.in_valid && io.in_ready;
  assign commit = hv && io.out_ready;
`ifdef ALU_RESULT_SKID_EN
  typedef enum logic {ONE, TWO} st_t;
  st_t st, st_n;
  alu_entry_t s;
  assign io.in_ready = st == ONE && !io.flush;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) st <= ONE;
    else st <= st_n;
  always_comb begin
    st_n = st;
    st_n = io.flush ? ONE :
           (st == ONE && acc && hv && !io.out_ready) ? TWO :
           (st == TWO && commit) ? ONE : st;
  end
`else
  assign io.in_ready = (!hv || io.out_ready) && !io.flush;
`endif
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      h <= '0;
      hv <= 1'b0;
      flags_q <= '0;
`ifdef ALU_RESULT_SKID_EN
      s <= '0;
`endif
    end else begin
      if (commit && h.set_flags && !io.flush) flags_q <= h.nzcv;
      if (io.flush) hv <= 1'b0;
`ifdef ALU_RESULT_SKID_EN
      else if (st == TWO) h <= commit ? s : h;
      else if (acc && hv && !io.out_ready) s <= ent;
`endif
      else if (acc) begin
        h <= ent;
        hv <= 1'b1;
      end else if (commit) hv <= 1'b0;
    end
  assign io.out_valid = hv;
  assign io.out_result = h.sum;
  assign io.out_dest = h.dest;
  assign io.out_flags = h.nzcv;
  assign io.flags = flags_q;
endmodule
